mult_div_unit: RTL and testbench
================================

Name: mult_div_unit

Overview:
- Iterative multiply/divide unit sitting beside the 32-bit adder in the EX stage of the MIPS datapath.
- Consumes the same A/B operand buses and executes MULT, MULTU, DIV and DIVU with a shift-and-add / restoring-subtract loop, one bit per cycle.
- Holds the architectural HI/LO registers that MFHI/MFLO read and MTHI/MTLO write.
- Raises Busy so the control unit can stall dependent HI/LO accesses.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- CNT_W, 6, iteration counter width; must hold the value WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- Start  input  1  launch an operation; sampled only in IDLE.
- Op  input  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- A  input  WIDTH  multiplicand / dividend (rs).
- B  input  WIDTH  multiplier / divisor (rt).
- MTHI  input  1  write A into HI.
- MTLO  input  1  write A into LO.
- HI  output  WIDTH  HI register (product high half / remainder).
- LO  output  WIDTH  LO register (product low half / quotient).
- Busy  output  1  operation in progress.
- Done  output  1  one-cycle pulse; HI/LO hold the new result in the same cycle.
- DivZero  output  1  one-cycle pulse with Done when a divide had B==0.

Behaviour:
- Reset (reset=0, asynchronous): HI=0, LO=0, Busy=0, Done=0, DivZero=0, state=IDLE, counter=0. Reset mid-operation aborts the operation with no partial HI/LO update.
- FSM states: IDLE, RUN, FIX.
  - IDLE: on Start=1, latch Op, |A|, |B| and sign flags, then go to RUN with counter=WIDTH. Magnitudes are taken only for signed ops; unsigned ops latch A and B raw.
  - IDLE, divide with B==0: no iteration. Go directly to FIX-skip: on the next edge Done=1, DivZero=1, HI/LO unchanged, Busy returns to 0.
  - RUN: one iteration per edge; counter decrements; after the edge where counter reaches 0, go to FIX.
  - FIX: apply sign correction, write HI/LO, pulse Done, return to IDLE.
- Latency: Start sampled at edge k. Busy=1 from edge k through edge k+33. HI/LO are written and Done=1 after edge k+33, i.e. 33 cycles of Busy. Busy drops on the same edge that Done rises. For divide-by-zero, Done follows at edge k+1.
- Multiply: 2*WIDTH-bit accumulator, shift-add on the multiplier LSB, WIDTH+1-bit partial sum (carry retained). Signed: if A[31]^B[31], the product is negated in two's complement across all 64 bits. {HI,LO} = product.
- Divide (restoring): remainder register WIDTH+1 bits. Each step shifts in the next dividend bit, trial-subtracts the divisor, keeps the result if non-negative, and sets the quotient bit.
  - Signed quotient is negated if the operand signs differ.
  - Signed remainder takes the sign of the dividend.
  - LO = quotient, HI = remainder.
  - DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0 (wraps, no trap).
- No overflow flag is produced; multiply cannot overflow 64 bits.
- Start while Busy=1: ignored, no queuing.
- MTHI/MTLO:
  - In IDLE with Start=0: the addressed register takes A on the next edge. Both asserted writes A into both.
  - Asserted together with Start in IDLE: Start wins, move ignored.
  - While Busy=1: ignored (control must stall).
- Op, A and B are don't-care after the Start edge; the internal latched copies are used.
- Done and DivZero are never high for more than one cycle, and never high while Busy=1.

Test Plan:
- MULTU A=0xFFFFFFFF B=0xFFFFFFFF -> after 33 cycles Done=1, HI=0xFFFFFFFE, LO=0x00000001, Busy low same cycle.
- MULT A=0xFFFFFFFD (-3) B=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB; MULT -3*-7 -> HI=0, LO=0x15.
- DIV A=-7 B=2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1); DIVU A=100 B=7 -> LO=14, HI=2; DIV 0x80000000 by -1 -> LO=0x80000000, HI=0.
- DIVU A=5 B=0 with HI=0x11, LO=0x22 preloaded via MTHI/MTLO -> Done and DivZero high one cycle after Start, HI=0x11, LO=0x22.
- Start MULTU 3*4, pulse Start with Op=DIVU and MTLO at cycle 10 -> both ignored; Done at cycle 33 with HI=0, LO=12.
- Start MULT 0x12345678*0x9ABCDEF0, drop reset at cycle 15 -> HI=LO=0, Busy=0 immediately; after release, a new MULTU 2*3 gives LO=6 after 33 cycles.

Source files
------------

// File: rtl/mult_div_unit_if.sv
// Operand and result bundle between the EX-stage control and the multiply/divide unit.
interface mult_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             Start;
    logic [1:0]       Op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             MTHI;
    logic             MTLO;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;
    logic             Busy;
    logic             Done;
    logic             DivZero;

    modport master (
        output Start, Op, A, B, MTHI, MTLO,
        input  HI, LO, Busy, Done, DivZero
    );

    modport slave (
        input  Start, Op, A, B, MTHI, MTLO,
        output HI, LO, Busy, Done, DivZero
    );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO registers; one bit per cycle,
// operands are reduced to magnitudes up front and the sign is fixed in a final cycle.
module mult_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic           clk,
    input  logic           reset,
    mult_div_unit_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               isDiv_q, isDiv_d;
    logic               skip_q, skip_d;
    logic               negRes_q, negRes_d;
    logic               negRem_q, negRem_d;
    logic [WIDTH-1:0]   opB_q, opB_d;
    logic [WIDTH-1:0]   accHi_q, accHi_d;
    logic [WIDTH-1:0]   accLo_q, accLo_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;
    logic               divZero_q, divZero_d;

    logic               isSigned;
    logic               signA;
    logic               signB;
    logic [WIDTH-1:0]   magA;
    logic [WIDTH-1:0]   magB;
    logic [WIDTH:0]     mulSum;
    logic [WIDTH:0]     divShift;
    logic               divFits;
    logic [WIDTH-1:0]   divSub;
    logic [2*WIDTH-1:0] prodRaw;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   rem;

    assign bus.HI      = hi_q;
    assign bus.LO      = lo_q;
    assign bus.Busy    = (state_q != IDLE);
    assign bus.Done    = done_q;
    assign bus.DivZero = divZero_q;

    // Op[0] selects the signed flavour; unsigned operands pass through untouched.
    always_comb begin
        isSigned = bus.Op[0];
        signA    = isSigned & bus.A[WIDTH-1];
        signB    = isSigned & bus.B[WIDTH-1];
        magA     = signA ? -bus.A : bus.A;
        magB     = signB ? -bus.B : bus.B;

        mulSum   = {1'b0, accHi_q} + {1'b0, (accLo_q[0] ? opB_q : '0)};
        divShift = {accHi_q, accLo_q[WIDTH-1]};
        divFits  = (divShift >= {1'b0, opB_q});
        divSub   = divShift[WIDTH-1:0] - opB_q;

        prodRaw  = {accHi_q, accLo_q};
        prod     = negRes_q ? -prodRaw : prodRaw;
        quot     = negRes_q ? -accLo_q : accLo_q;
        rem      = negRem_q ? -accHi_q : accHi_q;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        isDiv_d   = isDiv_q;
        skip_d    = skip_q;
        negRes_d  = negRes_q;
        negRem_d  = negRem_q;
        opB_d     = opB_q;
        accHi_d   = accHi_q;
        accLo_d   = accLo_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        divZero_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.Start) begin
                    isDiv_d  = bus.Op[1];
                    negRes_d = signA ^ signB;
                    negRem_d = signA;
                    accHi_d  = '0;
                    cnt_d    = CNT_W'(WIDTH);
                    if (bus.Op[1]) begin
                        opB_d   = magB;
                        accLo_d = magA;
                    end else begin
                        opB_d   = magA;
                        accLo_d = magB;
                    end
                    if (bus.Op[1] && (bus.B == '0)) begin
                        skip_d  = 1'b1;
                        cnt_d   = '0;
                        state_d = FIX;
                    end else begin
                        skip_d  = 1'b0;
                        state_d = RUN;
                    end
                end else begin
                    if (bus.MTHI) hi_d = bus.A;
                    if (bus.MTLO) lo_d = bus.A;
                end
            end

            RUN: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (isDiv_q) begin
                    // Quotient bits enter at the bottom as dividend bits leave the top.
                    if (divFits) begin
                        accHi_d = divSub;
                        accLo_d = {accLo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        accHi_d = divShift[WIDTH-1:0];
                        accLo_d = {accLo_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    accHi_d = mulSum[WIDTH:1];
                    accLo_d = {mulSum[0], accLo_q[WIDTH-1:1]};
                end
                if (cnt_q == CNT_W'(1)) state_d = FIX;
            end

            FIX: begin
                done_d  = 1'b1;
                skip_d  = 1'b0;
                state_d = IDLE;
                if (skip_q) begin
                    divZero_d = 1'b1;
                end else if (isDiv_q) begin
                    hi_d = rem;
                    lo_d = quot;
                end else begin
                    hi_d = prod[2*WIDTH-1:WIDTH];
                    lo_d = prod[WIDTH-1:0];
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            isDiv_q   <= 1'b0;
            skip_q    <= 1'b0;
            negRes_q  <= 1'b0;
            negRem_q  <= 1'b0;
            opB_q     <= '0;
            accHi_q   <= '0;
            accLo_q   <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            divZero_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            isDiv_q   <= isDiv_d;
            skip_q    <= skip_d;
            negRes_q  <= negRes_d;
            negRem_q  <= negRem_d;
            opB_q     <= opB_d;
            accHi_q   <= accHi_d;
            accLo_q   <= accLo_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
            divZero_q <= divZero_d;
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: a vector table of full operations plus
// hand-written sequences for divide-by-zero, moves, ignored starts and reset abort.
module tb_mult_div_unit;

    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_MULT  = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_DIV   = 2'b11;
    localparam int         NVEC     = 13;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expHi;
        logic [31:0] expLo;
    } vec_t;

    logic clk;
    logic reset;
    int   checkCount;
    int   failCount;
    vec_t vecs [NVEC];

    mult_div_unit_if #(.WIDTH(32)) bus ();

    mult_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its hand-computed expectation.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Launch one operation; returns 1 ns after the Start edge with junk on the operand bus.
    task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.Op    = op;
        bus.A     = a;
        bus.B     = b;
        bus.Start = 1'b1;
        @(posedge clk);
        #1;
        bus.Start = 1'b0;
        bus.Op    = 2'($urandom);
        bus.A     = $urandom;
        bus.B     = $urandom;
    endtask

    // Count edges until Done, bounded, noting whether Busy stayed high before it.
    task automatic waitDone(output int cycles, output logic busyOk);
        cycles = 0;
        busyOk = 1'b1;
        while (cycles < 40) begin
            @(posedge clk);
            #1;
            cycles++;
            if (bus.Done) break;
            if (!bus.Busy) busyOk = 1'b0;
        end
    endtask

    task automatic moveOp(input logic hiEn, input logic loEn, input logic [31:0] val);
        bus.MTHI = hiEn;
        bus.MTLO = loEn;
        bus.A    = val;
        @(posedge clk);
        #1;
        bus.MTHI = 1'b0;
        bus.MTLO = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] simulation timeout");
    end

    initial begin
        int   n;
        logic ok;

        checkCount = 0;
        failCount  = 0;
        reset      = 1'b0;
        bus.Start  = 1'b0;
        bus.Op     = 2'b00;
        bus.A      = '0;
        bus.B      = '0;
        bus.MTHI   = 1'b0;
        bus.MTLO   = 1'b0;

        vecs[0]  = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[1]  = '{OP_MULT,  32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
        vecs[2]  = '{OP_MULT,  32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'h0000_0000, 32'h0000_0015};
        vecs[3]  = '{OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[4]  = '{OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14};
        vecs[5]  = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        vecs[6]  = '{OP_MULT,  32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001};
        vecs[7]  = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        vecs[8]  = '{OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
        vecs[9]  = '{OP_DIVU,  32'hFFFF_FFFF, 32'd1,         32'h0000_0000, 32'hFFFF_FFFF};
        vecs[10] = '{OP_DIV,   32'hFFFF_FFF8, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0008};
        vecs[11] = '{OP_MULTU, 32'd0,         32'd5,         32'h0000_0000, 32'h0000_0000};
        vecs[12] = '{OP_DIVU,  32'd3,         32'd10,        32'h0000_0003, 32'h0000_0000};

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_hi",      bus.HI,      32'h0);
        checkOutput("reset_lo",      bus.LO,      32'h0);
        checkOutput("reset_busy",    32'(bus.Busy),    32'h0);
        checkOutput("reset_done",    32'(bus.Done),    32'h0);
        checkOutput("reset_divzero", 32'(bus.DivZero), 32'h0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b);
            checkOutput($sformatf("vec%0d_busy_start", i), 32'(bus.Busy), 32'h1);
            waitDone(n, ok);
            checkOutput($sformatf("vec%0d_latency", i),    32'(n),           32'd33);
            checkOutput($sformatf("vec%0d_busy_run", i),   32'(ok),          32'h1);
            checkOutput($sformatf("vec%0d_busy_done", i),  32'(bus.Busy),    32'h0);
            checkOutput($sformatf("vec%0d_divzero", i),    32'(bus.DivZero), 32'h0);
            checkOutput($sformatf("vec%0d_hi", i),         bus.HI,           vecs[i].expHi);
            checkOutput($sformatf("vec%0d_lo", i),         bus.LO,           vecs[i].expLo);
            @(posedge clk);
            #1;
            checkOutput($sformatf("vec%0d_done_pulse", i), 32'(bus.Done),    32'h0);
        end

        // Moves: both at once, then each alone must leave the other register alone.
        moveOp(1'b1, 1'b1, 32'h55);
        checkOutput("mt_both_hi", bus.HI, 32'h55);
        checkOutput("mt_both_lo", bus.LO, 32'h55);
        moveOp(1'b1, 1'b0, 32'h11);
        checkOutput("mthi_hi", bus.HI, 32'h11);
        checkOutput("mthi_lo", bus.LO, 32'h55);
        moveOp(1'b0, 1'b1, 32'h22);
        checkOutput("mtlo_hi", bus.HI, 32'h11);
        checkOutput("mtlo_lo", bus.LO, 32'h22);

        // Divide by zero finishes one edge after Start and leaves HI/LO alone.
        applyStimulus(OP_DIVU, 32'd5, 32'd0);
        checkOutput("dz_busy_start", 32'(bus.Busy), 32'h1);
        checkOutput("dz_done_early", 32'(bus.Done), 32'h0);
        @(posedge clk);
        #1;
        checkOutput("dz_done",    32'(bus.Done),    32'h1);
        checkOutput("dz_divzero", 32'(bus.DivZero), 32'h1);
        checkOutput("dz_busy",    32'(bus.Busy),    32'h0);
        checkOutput("dz_hi",      bus.HI,           32'h11);
        checkOutput("dz_lo",      bus.LO,           32'h22);
        @(posedge clk);
        #1;
        checkOutput("dz_done_clear",    32'(bus.Done),    32'h0);
        checkOutput("dz_divzero_clear", 32'(bus.DivZero), 32'h0);

        // Start beats a simultaneous MTLO.
        bus.MTLO = 1'b1;
        applyStimulus(OP_MULTU, 32'd2, 32'd3);
        bus.MTLO = 1'b0;
        checkOutput("start_vs_mtlo_lo", bus.LO, 32'h22);
        waitDone(n, ok);
        checkOutput("start_vs_mtlo_latency", 32'(n), 32'd33);
        checkOutput("start_vs_mtlo_result",  bus.LO, 32'd6);

        // Start and MTLO while busy are both ignored.
        applyStimulus(OP_MULTU, 32'd3, 32'd4);
        repeat (9) @(posedge clk);
        #1;
        bus.Start = 1'b1;
        bus.Op    = OP_DIVU;
        bus.MTLO  = 1'b1;
        bus.A     = 32'hDEAD_BEEF;
        bus.B     = 32'd0;
        @(posedge clk);
        #1;
        bus.Start = 1'b0;
        bus.MTLO  = 1'b0;
        checkOutput("busy_ignore_lo",      bus.LO,           32'd6);
        checkOutput("busy_ignore_divzero", 32'(bus.DivZero), 32'h0);
        waitDone(n, ok);
        checkOutput("busy_ignore_latency", 32'(n + 10), 32'd33);
        checkOutput("busy_ignore_hi",      bus.HI,      32'h0);
        checkOutput("busy_ignore_lo_res",  bus.LO,      32'd12);
        @(posedge clk);
        #1;
        checkOutput("busy_ignore_no_second_done", 32'(bus.Done), 32'h0);
        checkOutput("busy_ignore_idle",           32'(bus.Busy), 32'h0);

        // Reset mid-operation aborts and clears HI/LO immediately.
        applyStimulus(OP_MULT, 32'h1234_5678, 32'h9ABC_DEF0);
        repeat (14) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        checkOutput("abort_hi",   bus.HI,           32'h0);
        checkOutput("abort_lo",   bus.LO,           32'h0);
        checkOutput("abort_busy", 32'(bus.Busy),    32'h0);
        checkOutput("abort_done", 32'(bus.Done),    32'h0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus(OP_MULTU, 32'd2, 32'd3);
        waitDone(n, ok);
        checkOutput("after_reset_latency", 32'(n), 32'd33);
        checkOutput("after_reset_hi",      bus.HI, 32'h0);
        checkOutput("after_reset_lo",      bus.LO, 32'd6);

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
